// File: rtl/biu_pkg.sv
//==============================================================================
// Module : biu_pkg
// Brief  : Shared constants for the bus interface unit cycle sequencer.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package biu_pkg;

   localparam int ADDR_W_DEF = 20;
   localparam int DATA_W_DEF = 8;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_T1   = 3'd1;
   localparam logic [2:0] S_T2   = 3'd2;
   localparam logic [2:0] S_T3   = 3'd3;
   localparam logic [2:0] S_TW   = 3'd4;
   localparam logic [2:0] S_T4   = 3'd5;

   localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/bus_wait_timer.sv
//==============================================================================
// Module : bus_wait_timer
// Brief  : Tw-cycle counter; flags the TW cycle in which WAIT_MAX is reached.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module bus_wait_timer #(
   parameter int WAIT_MAX = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   localparam logic [2:0] LIMIT = 3'(WAIT_MAX - 1);

   logic [2:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= 3'd0;
      end else if (clear) begin
         cnt <= 3'd0;
      end else if (tick && cnt != 3'd7) begin
         cnt <= cnt + 3'd1;
      end
   end

   // cnt counts completed Tw cycles, so the WAIT_MAX-th Tw sees LIMIT
   assign expired = tick && (cnt == LIMIT);

endmodule

`default_nettype wire

// File: rtl/bus_cycle_ctrl.sv
//==============================================================================
// Module : bus_cycle_ctrl
// Brief  : 8086-style T1/T2/T3/Tw/T4 bus-cycle sequencer with registered strobes.
//          Optional Tw timeout enabled by macro BUS_WAIT_TIMEOUT_EN.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module bus_cycle_ctrl
   import biu_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int WAIT_MAX = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] data_in,
   output logic              ale,
   output logic [ADDR_W-1:0] addr_out,
   output logic              rd_n,
   output logic              wr_n,
   output logic              den_n,
   output logic              dt_r,
   output logic [DATA_W-1:0] data_out,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              done,
   output logic              err
);

   logic [2:0]        state;
   logic [2:0]        next_state;
   logic              accept;
   logic              timeout;
   logic              wr_q;
   logic [DATA_W-1:0] wdata_q;

   logic ale_d, rd_n_d, wr_n_d, den_n_d, rsp_valid_d, done_d, err_d;
   logic capture;

   assign req_ready = (state == S_IDLE || state == S_T4) && !rst;
   assign accept    = req_valid && req_ready;

`ifdef BUS_WAIT_TIMEOUT_EN
   bus_wait_timer #(
      .WAIT_MAX (WAIT_MAX)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == S_T2),
      .tick    (state == S_TW),
      .expired (timeout)
   );
`else
   // No timer: TW waits indefinitely; WAIT_MAX has no effect here
   assign timeout = (WAIT_MAX < 0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = S_IDLE;
      case (state)
         S_IDLE:      next_state = accept ? S_T1 : S_IDLE;
         S_T1:        next_state = S_T2;
         S_T2:        next_state = S_T3;
         S_T3, S_TW:  next_state = (mem_ready || timeout) ? S_T4 : S_TW;
         S_T4:        next_state = accept ? S_T1 : S_IDLE;
         default:     next_state = S_IDLE;
      endcase
   end

   // Outputs are registered, so their next values derive from next_state
   always_comb begin
      ale_d       = accept;
      rd_n_d      = 1'b1;
      wr_n_d      = 1'b1;
      den_n_d     = 1'b1;
      if (next_state == S_T2 || next_state == S_T3 || next_state == S_TW) begin
         rd_n_d  = wr_q;
         wr_n_d  = !wr_q;
         den_n_d = 1'b0;
      end
      done_d      = (next_state == S_T4);
      rsp_valid_d = (next_state == S_T4) && !wr_q;
      err_d       = (state == S_TW) && !mem_ready && timeout;
      capture     = (state == S_T3 || state == S_TW) && (next_state == S_T4) && !wr_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q      <= 1'b0;
         wdata_q   <= '0;
         ale       <= 1'b0;
         addr_out  <= '0;
         rd_n      <= 1'b1;
         wr_n      <= 1'b1;
         den_n     <= 1'b1;
         dt_r      <= 1'b0;
         data_out  <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         ale       <= ale_d;
         rd_n      <= rd_n_d;
         wr_n      <= wr_n_d;
         den_n     <= den_n_d;
         rsp_valid <= rsp_valid_d;
         done      <= done_d;
         err       <= err_d;
         if (accept) begin
            wr_q     <= req_wr;
            wdata_q  <= req_wdata;
            addr_out <= req_addr;
            dt_r     <= req_wr;
         end
         if (state == S_T1 && wr_q) begin
            data_out <= wdata_q;
         end
         if (capture) begin
            rsp_data <= mem_ready ? data_in : DATA_W'(TIMEOUT_FILL);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bus_cycle_ctrl.sv
//==============================================================================
// Module : tb_bus_cycle_ctrl
// Brief  : Directed self-checking bench for bus_cycle_ctrl (BUS_WAIT_TIMEOUT_EN aware).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_bus_cycle_ctrl;

   localparam int ADDR_W = 20;
   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_wr;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] data_in;
   logic              ale;
   logic [ADDR_W-1:0] addr_out;
   logic              rd_n;
   logic              wr_n;
   logic              den_n;
   logic              dt_r;
   logic [DATA_W-1:0] data_out;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              done;
   logic              err;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   bus_cycle_ctrl #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .WAIT_MAX (7)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .mem_ready (mem_ready),
      .data_in   (data_in),
      .ale       (ale),
      .addr_out  (addr_out),
      .rd_n      (rd_n),
      .wr_n      (wr_n),
      .den_n     (den_n),
      .dt_r      (dt_r),
      .data_out  (data_out),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .done      (done),
      .err       (err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int wr_low;
      int rsp_seen;
      int done_seen;
      int err_seen;

      rst       = 1'b1;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      mem_ready = 1'b0;
      data_in   = '0;

      // Reset values
      #12;
      chk("rst_strobes", {ale, rd_n, wr_n, den_n, dt_r, rsp_valid, done, err}, 32'b0111_0000);
      chk("rst_addr", addr_out, 32'h0);
      chk("rst_data", {data_out, rsp_data}, 32'h0);
      chk("rst_ready", req_ready, 32'h0);
      rst = 1'b0;
      tick();
      chk("idle_ready", req_ready, 32'h1);

      // Reset in the middle of T2 of a read
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 20'h12345;
      mem_ready = 1'b1; data_in = 8'h33;
      tick();
      req_valid = 1'b0;
      tick();
      chk("t2_rd_low", {rd_n, den_n}, 32'b00);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_strobes", {rd_n, den_n, wr_n}, 32'b111);
      #3 rst = 1'b0;
      tick();
      chk("post_rst_idle", {req_ready, rsp_valid, done}, 32'b100);
      tick();
      tick();
      chk("post_rst_no_rsp", {rsp_valid, done, rsp_data}, 32'h0);

      // Zero-wait read
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 20'h1A2B4;
      mem_ready = 1'b1; data_in = 8'h5C;
      tick();
      req_valid = 1'b0;
      chk("rd_c1_ale", {ale, rd_n, den_n, dt_r}, 32'b1110);
      chk("rd_c1_addr", addr_out, 32'h1A2B4);
      tick();
      chk("rd_c2", {ale, rd_n, den_n, wr_n}, 32'b0001);
      tick();
      chk("rd_c3", {rd_n, rsp_valid, done}, 32'b000);
      tick();
      chk("rd_c4", {rd_n, den_n, rsp_valid, done, err}, 32'b11110);
      chk("rd_c4_data", rsp_data, 32'h5C);
      tick();
      chk("rd_c5", {rsp_valid, done, req_ready}, 32'b001);
      chk("rd_hold_data", rsp_data, 32'h5C);

      // Write with two wait states
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 20'hFFFF0; req_wdata = 8'hA7;
      mem_ready = 1'b0;
      wr_low = 0; rsp_seen = 0;
      tick();
      req_valid = 1'b0;
      chk("wr_c1", {ale, dt_r, wr_n}, 32'b111);
      chk("wr_c1_addr", addr_out, 32'hFFFF0);
      for (int c = 1; c <= 6; c++) begin
         if (c > 1) tick();
         if (wr_n == 1'b0) wr_low++;
         if (rsp_valid) rsp_seen++;
         if (c == 2) chk("wr_c2", {wr_n, den_n, dt_r, rd_n, data_out}, {4'b0011, 8'hA7});
         if (c == 5) mem_ready = 1'b1;
         if (c == 6) chk("wr_c6", {done, wr_n, dt_r, data_out}, {3'b111, 8'hA7});
      end
      chk("wr_low_cycles", wr_low, 32'd4);
      chk("wr_no_rsp", rsp_seen, 32'd0);
      tick();
      chk("wr_after", {done, req_ready}, 32'b01);

      // Back-to-back reads with a request held under backpressure
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 20'h04000;
      mem_ready = 1'b1; data_in = 8'h11;
      tick();
      req_valid = 1'b0;
      chk("b2b_c1", {ale, addr_out}, {1'b1, 20'h04000});
      tick();
      req_valid = 1'b1; req_addr = 20'h04001;
      #1 chk("bp_t2_ready", req_ready, 32'h0);
      tick();
      chk("bp_t3_ready", req_ready, 32'h0);
      chk("bp_t3_addr", addr_out, 32'h04000);
      tick();
      chk("b2b_c4", {rsp_valid, done, req_ready, rsp_data}, {3'b111, 8'h11});
      data_in = 8'h22;
      tick();
      req_valid = 1'b0;
      chk("b2b_c5", {ale, done, addr_out}, {2'b10, 20'h04001});
      tick();
      tick();
      tick();
      chk("b2b_c8", {rsp_valid, done, rsp_data}, {2'b11, 8'h22});
      tick();
      chk("b2b_c9", {ale, req_ready, rsp_valid}, 32'b010);

      // mem_ready stuck low on a read
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 20'h00777;
      mem_ready = 1'b0; data_in = 8'h3C;
      tick();
      req_valid = 1'b0;
`ifdef BUS_WAIT_TIMEOUT_EN
      for (int c = 2; c <= 10; c++) tick();
      chk("to_c10", {dut.state, err, done, rd_n}, {3'd4, 3'b000});
      tick();
      chk("to_c11", {err, done, rsp_valid, rd_n}, 32'b1111);
      chk("to_fill", rsp_data, 32'hFF);
      tick();
      chk("to_c12", {err, done, dut.state}, {2'b00, 3'd0});
`else
      done_seen = 0; err_seen = 0; rsp_seen = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (done) done_seen++;
         if (err) err_seen++;
         if (rsp_valid) rsp_seen++;
      end
      chk("stuck_state", {dut.state, rd_n, den_n}, {3'd4, 2'b00});
      chk("stuck_pulses", {done_seen[7:0], err_seen[7:0], rsp_seen[7:0]}, 32'h0);
      #2 rst = 1'b1;
      #1 chk("stuck_rst", {rd_n, den_n, err}, 32'b110);
      #3 rst = 1'b0;
      tick();
      chk("stuck_rst_idle", {req_ready, dut.state}, {1'b1, 3'd0});
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
